// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encodings and {N,Z,C,V} flag layout shared by the ALU pipeline
package alu_pipe_pkg;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_LSL = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_CMP = 3'd4;
   localparam logic [2:0] OP_LSR = 3'd5;
   localparam logic [2:0] OP_SET = 3'd6;
   localparam logic [2:0] OP_SUB = 3'd7;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flagsT;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; op/a/b/cinEn/flagsIn in, result/flagsOut/we out
module alu_core import alu_pipe_pkg::*; #(
   parameter int W = 8
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cinEn,
   input  flagsT        flagsIn,
   output logic [W-1:0] result,
   output flagsT        flagsOut,
   output logic         we
);
   logic         isSub;
   logic         cin;
   logic         c;
   logic         v;
   logic [W-1:0] bOp;
   logic [W:0]   sum;
   logic [W:0]   shl;
   logic [W:0]   shr;
   always_comb begin
      isSub = (op == OP_SUB) || (op == OP_CMP);
      bOp = isSub ? ~b : b;
      cin = cinEn ? flagsIn.c : isSub;
      sum = {1'b0, a} + {1'b0, bOp} + {{W{1'b0}}, cin};
      // The extra guard bit catches the last bit shifted out; oversized shifts fall to zero naturally
      shl = {1'b0, a} << b;
      shr = {a, 1'b0} >> b;
      result = sum[W-1:0];
      c = sum[W];
      v = (a[W-1] == bOp[W-1]) && (sum[W-1] != a[W-1]);
      case (op)
         OP_LSL: begin result = shl[W-1:0]; c = shl[W]; v = 1'b0; end
         OP_LSR: begin result = shr[W:1]; c = shr[0]; v = 1'b0; end
         OP_XOR: begin result = a ^ b; c = 1'b0; v = 1'b0; end
         OP_AND: begin result = a & b; c = 1'b0; v = 1'b0; end
         OP_SET: result = b;
         default: ;
      endcase
      flagsOut = (op == OP_SET) ? flagsIn : flagsT'({result[W-1], ~|result, c, v});
      we = op != OP_CMP;
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with {N,Z,C,V} flag register
//   Clk/Reset(async, active-low); InValid/InReady/InOp/InA/InB/InCinEn operation in;
//   OutValid/OutReady/OutResult/OutWe/OutFlags result out
module alu_pipe import alu_pipe_pkg::*; #(
   parameter int         W        = 8,
   parameter logic [3:0] FLAG_RST = 4'b0000
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         InValid,
   output logic         InReady,
   input  logic [2:0]   InOp,
   input  logic [W-1:0] InA,
   input  logic [W-1:0] InB,
   input  logic         InCinEn,
   output logic         OutValid,
   input  logic         OutReady,
   output logic [W-1:0] OutResult,
   output logic         OutWe,
   output logic [3:0]   OutFlags
);
   logic         s1Valid;
   logic [2:0]   s1Op;
   logic [W-1:0] s1A;
   logic [W-1:0] s1B;
   logic         s1CinEn;
   logic         s2Adv;
   logic [W-1:0] coreResult;
   logic         coreWe;
   flagsT        coreFlags;
   flagsT        flagReg;
   assign s2Adv    = !OutValid || OutReady;
   assign InReady  = !s1Valid || s2Adv;
   assign OutFlags = flagReg;
   // The ALU reads the live flag register, so an op directly behind a carry producer sees the new C
   alu_core #(.W(W)) uCore (
      .op      (s1Op),
      .a       (s1A),
      .b       (s1B),
      .cinEn   (s1CinEn),
      .flagsIn (flagReg),
      .result  (coreResult),
      .flagsOut(coreFlags),
      .we      (coreWe)
   );
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s1Valid   <= 1'b0;
         s1Op      <= OP_ADD;
         s1A       <= '0;
         s1B       <= '0;
         s1CinEn   <= 1'b0;
         OutValid  <= 1'b0;
         OutResult <= '0;
         OutWe     <= 1'b0;
         flagReg   <= flagsT'(FLAG_RST);
      end else begin
         if (InReady) s1Valid <= InValid;
         if (InReady && InValid) {s1Op, s1A, s1B, s1CinEn} <= {InOp, InA, InB, InCinEn};
         if (s2Adv) OutValid <= s1Valid;
         // Flags commit only on the S1->S2 move, so a stalled op never updates them twice
         if (s2Adv && s1Valid) begin
            OutResult <= coreResult;
            OutWe     <= coreWe;
            flagReg   <= coreFlags;
         end
      end
   end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning the operand and result width in bits (W >= 4).
REQ-002 SHALL have parameter FLAG_RST, default 4'b0000, meaning the reset value of the {N,Z,C,V} flag register.
REQ-003 SHALL have port Clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  meaning the reset, which is asynchronous and active-low.
REQ-005 SHALL have port InValid  input  1  meaning an operation is offered.
REQ-006 SHALL have port InReady  output  1  meaning the block accepts an operation this cycle.
REQ-007 SHALL have port InOp  input  3  meaning the arithmetic opcode (ADD, LSL, XOR, AND, CMP, LSR, SET, SUB encodings).
REQ-008 SHALL have port InA  input  W  meaning operand A.
REQ-009 SHALL have port InB  input  W  meaning operand B, or the shift amount, or the SET value.
REQ-010 SHALL have port InCinEn  input  1  meaning ADD/SUB/CMP use flag C as carry-in (multi-word chaining).
REQ-011 SHALL have port OutValid  output  1  meaning a result is presented.
REQ-012 SHALL have port OutReady  input  1  meaning the consumer takes the result.
REQ-013 SHALL have port OutResult  output  W  meaning the operation result.
REQ-014 SHALL have port OutWe  output  1  meaning the result is to be written back; 0 for CMP, 1 otherwise.
REQ-015 SHALL have port OutFlags  output  4  meaning the flag register {N,Z,C,V}.

Function
REQ-016 SHALL be a two-stage pipeline: S1 captures operands on InValid&&InReady; the combinational ALU runs between S1 and S2; S2 holds the result; latency 2 cycles, throughput 1 op/cycle.
REQ-017 SHALL advance S2 when !S2.valid || OutReady, and advance S1 into S2 when S1.valid && S2 advances; InReady = !S1.valid || S1 advances (no combinational path from InValid to InReady).
REQ-018 SHALL hold OutResult, OutWe and OutValid stable while OutValid && !OutReady.
REQ-019 SHALL compute ADD = A+B+cin, SUB/CMP = A+~B+cin', where cin = C if InCinEn else 0 (ADD) and cin' = C if InCinEn else 1 (SUB/CMP); C = carry out (SUB: 1 means no borrow); V = signed overflow.
REQ-020 SHALL compute LSL/LSR by B; B >= W yields result 0; C = last bit shifted out (0 when B = 0); V = 0.
REQ-021 SHALL compute XOR and AND bitwise, with C = 0 and V = 0.
REQ-022 SHALL compute SET result = B and leave all flags unchanged.
REQ-023 SHALL set N = result[W-1] and Z = (result == 0) for every op except SET; CMP updates all flags but OutWe = 0.
REQ-024 SHALL update the flag register in the same edge the op enters S2, so the op immediately behind reads updated C (back-to-back chaining with no bubble).
REQ-025 SHALL, under S2 stall, hold S1 and the flag register; a stalled op SHALL NOT update flags twice.
REQ-026 SHALL, with simultaneous input accept and output accept on a full pipe, shift both stages with no bubble and no loss.

Reset
REQ-027 SHALL, on Reset low, immediately clear S1.valid, S2.valid and OutValid, set OutResult = 0 and OutWe = 0, and load flags = FLAG_RST; in-flight ops are discarded.
REQ-028 SHALL drive InReady = 1 during the first cycle after Reset deasserts.

Structure
REQ-029 SHALL take opcode constants and a flags typedef (packed struct {N,Z,C,V}) with bit-index constants from the shared definitions package.
REQ-030 SHALL instantiate one combinational sub-module, alu_core (op, a, b, cin_en, flags_in -> result, flags_out, we), with the handshake and registers in alu_pipe.

Verification
REQ-031 SHALL cover W=8: ADD A=8'hFF, B=8'h01, InCinEn=0 -> two cycles later result 8'h00, we 1, flags N0 Z1 C1 V0.
REQ-032 SHALL cover 16-bit chain: ADD 8'hFF+8'h01 (cin off) then back-to-back ADD 8'h00+8'h00 InCinEn=1 -> second result 8'h01, C0.
REQ-033 SHALL cover CMP A=8'h05, B=8'h07 -> we 0, flags N1 Z0 C0 V0; following SET B=8'h3C -> result 8'h3C, flags unchanged.
REQ-034 SHALL cover LSL A=8'h81, B=1 -> 8'h02, C1; LSR A=8'h81, B=9 -> 8'h00, Z1.
REQ-035 SHALL cover OutReady held low 5 cycles with a stream of 4 ops -> InReady falls after 2 accepted, outputs stable, all 4 results delivered in order.
REQ-036 SHALL cover Reset asserted with both stages full -> OutValid 0 immediately, flags = FLAG_RST, no stale result afterwards.
